// File: rtl/fpu_pkg.sv
// Shared encodings and constants for the FPU normalize/round stage.
package fpu_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_MUL  = 2'b10;

  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;
  localparam int FRAC_W  = 23;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    SHIFT,
    ROUND,
    OUT
  } state_e;

endpackage

// File: rtl/fpu_round_ne.sv
// Combinational round-to-nearest-even and single-precision packing.
// With FPU_NORM_FLAGS_EN defined, also reports {overflow, underflow, inexact}.
module fpu_round_ne
  import fpu_pkg::*;
(
  input  logic              sign,
  input  logic [FRAC_W:0]   mant,
  input  logic              guard,
  input  logic              sticky,
  input  logic [8:0]        exp,
  input  logic              force_zero,
`ifdef FPU_NORM_FLAGS_EN
  input  logic              uflow_in,
  output logic [2:0]        flags,
`endif
  output logic [31:0]       result
);

  function automatic logic rne_inc(input logic lsb, input logic g, input logic s);
    return g & (s | lsb);
  endfunction

  logic              inc;
  logic              carry;
  logic [FRAC_W-1:0] frac_r;
  logic [8:0]        exp_r;

  // An all-ones mantissa that rounds up wraps the fraction to zero and bumps E.
  assign inc    = rne_inc(mant[0], guard, sticky);
  assign carry  = inc & (&mant);
  assign frac_r = mant[FRAC_W-1:0] + FRAC_W'(inc);
  assign exp_r  = exp + 9'(carry);

  always_comb begin
    result = {sign, 31'b0};
    if (force_zero)
      result = {sign, 31'b0};
    else if (exp_r >= 9'(EXP_MAX))
      result = {sign, 8'hFF, {FRAC_W{1'b0}}};
    else if (exp_r == 9'd0)
      result = {sign, 31'b0};
    else
      result = {sign, exp_r[7:0], frac_r};
  end

`ifdef FPU_NORM_FLAGS_EN
  always_comb begin
    flags = 3'b000;
    if (force_zero)
      flags = {1'b0, uflow_in, uflow_in};
    else if (exp_r >= 9'(EXP_MAX))
      flags = 3'b101;
    else if (exp_r == 9'd0)
      flags = 3'b011;
    else
      flags = {2'b00, guard | sticky};
  end
`endif

endmodule

// File: rtl/fpu_normalize.sv
// Final FPU stage: iterative normalize, round-nearest-even, IEEE-754 pack.
// Optional FPU_NORM_FLAGS_EN adds out_flags = {overflow, underflow, inexact}.
module fpu_normalize #(
  parameter int BIAS   = 127,
  parameter int MANT_W = 48,
  parameter int FRAC_W = 23
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [7:0]        in_exponent,
  input  logic [MANT_W-1:0] in_mantissa,
  input  logic [1:0]        in_operator,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef FPU_NORM_FLAGS_EN
  output logic [2:0]        out_flags,
`endif
  output logic [31:0]       out_result
);
  import fpu_pkg::*;

  // Smallest normal biased exponent; left shifting stops here.
  localparam logic [8:0] E_MIN_NORM = 9'(BIAS - 126);

  state_e            state, state_nxt;
  logic              sign_r, sticky_r, zero_r;
  logic [MANT_W-1:0] w_r;
  logic [8:0]        e_r;
  logic [31:0]       rnd_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (in_valid) state_nxt = ALIGN;
      ALIGN: if (w_r == '0 || w_r[MANT_W-1] || w_r[MANT_W-2]) state_nxt = ROUND;
             else state_nxt = SHIFT;
      SHIFT: if (e_r <= E_MIN_NORM || w_r[MANT_W-3]) state_nxt = ROUND;
      ROUND: state_nxt = OUT;
      OUT:   if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == OUT);
  end

  // Working mantissa/exponent: capture, single right align, iterative left shift.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (in_valid) begin
        sign_r   <= in_sign;
        e_r      <= {1'b0, in_exponent};
        sticky_r <= 1'b0;
        zero_r   <= 1'b0;
        if (in_operator == OP_ADD)      w_r <= MANT_W'({in_mantissa[24:0], 23'b0});
        else if (in_operator == OP_MUL) w_r <= in_mantissa;
        else                            w_r <= '0;
      end
      ALIGN: begin
        if (w_r == '0)
          zero_r <= 1'b1;
        else if (w_r[MANT_W-1]) begin
          w_r      <= w_r >> 1;
          sticky_r <= w_r[0];
          e_r      <= e_r + 9'd1;
        end
      end
      SHIFT: begin
        if (e_r <= E_MIN_NORM)
          zero_r <= 1'b1;
        else begin
          w_r <= w_r << 1;
          e_r <= e_r - 9'd1;
        end
      end
      default: ;
    endcase
  end

`ifdef FPU_NORM_FLAGS_EN
  logic       uflow_r;
  logic [2:0] rnd_flags;

  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) uflow_r <= 1'b0;
    else if (state == SHIFT && e_r <= E_MIN_NORM) uflow_r <= 1'b1;
  end
`endif

  fpu_round_ne u_round (
    .sign       (sign_r),
    .mant       (w_r[MANT_W-2 -: FRAC_W+1]),
    .guard      (w_r[MANT_W-FRAC_W-3]),
    .sticky     ((|w_r[MANT_W-FRAC_W-4:0]) | sticky_r),
    .exp        (e_r),
    .force_zero (zero_r),
`ifdef FPU_NORM_FLAGS_EN
    .uflow_in   (uflow_r),
    .flags      (rnd_flags),
`endif
    .result     (rnd_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              out_result <= '0;
    else if (state == ROUND) out_result <= rnd_result;
  end

`ifdef FPU_NORM_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              out_flags <= '0;
    else if (state == ROUND) out_flags <= rnd_flags;
  end
`endif

endmodule

// File: tb/tb_fpu_normalize.sv
// Directed self-checking bench for fpu_normalize (flags checked when FPU_NORM_FLAGS_EN).
module tb_fpu_normalize;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exponent;
  logic [47:0] in_mantissa;
  logic [1:0]  in_operator;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
`ifdef FPU_NORM_FLAGS_EN
  logic [2:0]  out_flags;
`endif

  int n_checks = 0;
  int n_errors = 0;

  fpu_normalize dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sign     (in_sign),
    .in_exponent (in_exponent),
    .in_mantissa (in_mantissa),
    .in_operator (in_operator),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
`ifdef FPU_NORM_FLAGS_EN
    .out_flags   (out_flags),
`endif
    .out_result  (out_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [7:0] e, input logic [47:0] m, input logic [1:0] op);
    in_valid    = 1'b1;
    in_sign     = s;
    in_exponent = e;
    in_mantissa = m;
    in_operator = op;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Returns edges counted from the accepting edge (inclusive) until out_valid.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic s, input logic [7:0] e,
                        input logic [47:0] m, input logic [1:0] op,
                        input logic [31:0] exp_res, input logic [2:0] exp_flg,
                        input int exp_lat);
    int lat;
    check({tag, "/in_ready"}, 32'(in_ready), 32'd1);
    drive(s, e, m, op);
    wait_valid(lat);
    check({tag, "/out_valid"}, 32'(out_valid), 32'd1);
    if (exp_lat > 0) check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "/result"}, out_result, exp_res);
`ifdef FPU_NORM_FLAGS_EN
    check({tag, "/flags"}, 32'(out_flags), 32'(exp_flg));
`else
    if (exp_flg === 3'bxxx) check({tag, "/flags_arg"}, 32'(exp_flg), 32'd0);
`endif
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "/drop_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int lat;
    int stale;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_sign     = 1'b0;
    in_exponent = 8'd0;
    in_mantissa = 48'd0;
    in_operator = 2'b00;
    out_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset/in_ready", 32'(in_ready), 32'd1);
    check("reset/out_valid", 32'(out_valid), 32'd0);
    check("reset/out_result", out_result, 32'd0);
`ifdef FPU_NORM_FLAGS_EN
    check("reset/out_flags", 32'(out_flags), 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("mul_2p25",   1'b0, 8'd127, 48'h900000000000, 2'b10, 32'h40100000, 3'b000, 3);
    run_op("add_2p0",    1'b0, 8'd127, 48'h000001000000, 2'b00, 32'h40000000, 3'b000, 3);
    run_op("add_1p0",    1'b0, 8'd127, 48'h000000800000, 2'b00, 32'h3F800000, 3'b000, 3);
    run_op("add_neg1",   1'b1, 8'd127, 48'h000000800000, 2'b00, 32'hBF800000, 3'b000, 3);
    run_op("cancel_23",  1'b0, 8'd127, 48'h000000000001, 2'b00, 32'h34000000, 3'b000, 26);
    run_op("cancel_uf",  1'b0, 8'd10,  48'h000000000001, 2'b00, 32'h00000000, 3'b011, 0);
    run_op("rnd_carry",  1'b0, 8'd127, 48'h000001FFFFFF, 2'b00, 32'h40800000, 3'b001, 3);
    run_op("tie_even",   1'b0, 8'd127, 48'h000001000001, 2'b00, 32'h40000000, 3'b001, 3);
    run_op("tie_odd",    1'b0, 8'd127, 48'h000001000003, 2'b00, 32'h40000002, 3'b001, 3);
    run_op("align_stk",  1'b0, 8'd126, 48'h800000800001, 2'b10, 32'h3F800001, 3'b001, 3);
    run_op("mul_ovf",    1'b1, 8'd254, 48'h800000000000, 2'b10, 32'hFF800000, 3'b101, 3);
    run_op("bad_op",     1'b0, 8'd127, 48'h000000800123, 2'b01, 32'h00000000, 3'b000, 3);
    run_op("exp0_flush", 1'b1, 8'd0,   48'h000000800000, 2'b00, 32'h80000000, 3'b011, 3);

    // Backpressure: result must hold while out_ready stays low.
    drive(1'b0, 8'd127, 48'h900000000000, 2'b10);
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      check("hold/out_valid", 32'(out_valid), 32'd1);
      check("hold/out_result", out_result, 32'h40100000);
      check("hold/in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("hold/release", 32'(out_valid), 32'd0);

    // Reset in the middle of a long left-shift sequence.
    drive(1'b0, 8'd127, 48'h000000000001, 2'b00);
    repeat (5) @(posedge clk);
    #1;
    check("mid/busy", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst/out_valid", 32'(out_valid), 32'd0);
    check("rst/in_ready", 32'(in_ready), 32'd1);
    check("rst/out_result", out_result, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) stale++;
    end
    check("rst/no_stale", 32'(stale), 32'd0);
    check("rst/result_zero", out_result, 32'd0);

    run_op("after_rst",  1'b0, 8'd127, 48'h000001000000, 2'b00, 32'h40000000, 3'b000, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fpu_normalize.md
Name: fpu_normalize

Overview:
Final FPU pipeline stage, directly downstream of the compute stage; consumes its registered sign, aligned exponent, 48-bit raw mantissa and operator.
Normalizes the mantissa iteratively and rounds to nearest-even. Packs an IEEE-754 single-precision result.
Uses a valid/ready handshake, so it can stall while performing multi-cycle left shifts after cancellation.

Parameters:
BIAS, 127, exponent bias; used for documentation and checks only (only the default is supported)
MANT_W, 48, raw input mantissa width
FRAC_W, 23, stored fraction width of the result

Ports:
clk  in  1  clock; single clock domain
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input word valid
in_ready  out  1  stage can accept; high only in IDLE
in_sign  in  1  result sign from compute stage
in_exponent  in  8  biased exponent; for multiply, already e1+e2-BIAS
in_mantissa  in  48  raw sum (bits 24:0, hidden point at bit 23) or product (point at bit 46)
in_operator  in  2  00 add, 10 multiply, others invalid
out_valid  out  1  result valid; held until accepted
out_ready  in  1  downstream accepts
out_result  out  32  {sign, exp[7:0], frac[22:0]}

Behaviour:
- Reset: state IDLE, in_ready=1, out_valid=0, out_result=0. Reset asserted in any state aborts the operation; no partial output.
- IDLE: in_valid&in_ready captures the word into a 48-bit working register W and a 9-bit exponent E.
  - Add: W={in_mantissa[24:0],23'b0}.
  - Multiply: W=in_mantissa.
  - Other operator: W=0.
  - Next state is ALIGN.
- ALIGN (1 cycle):
  - W==0: result is signed zero {in_sign,31'b0}; go to ROUND with zero bypass.
  - W[47]=1: W>>1 with the shifted-out bit ORed into sticky, E+1; go to ROUND.
  - W[46]=1: go to ROUND.
  - Otherwise: go to SHIFT.
- SHIFT: one left shift per cycle, E-1 per shift, while W[46]==0 and E>1.
  - Exit to ROUND when W[46]=1.
  - If E reaches 1 with W[46]==0: underflow; result flushes to signed zero.
- ROUND:
  - Fields: mant=W[46:23], guard=W[22], sticky=|W[21:0] OR the ALIGN sticky.
  - Round up when guard&(sticky|mant[0]).
  - Carry out of 24 bits: mant=0x800000, E+1.
  - E>=255: overflow; result {sign,8'hFF,23'b0} (infinity).
  - E==0: flush to signed zero.
  - Otherwise: {sign,E[7:0],mant[22:0]}.
  - Registers out_result, sets out_valid; next state is OUT.
- OUT: out_valid=1 and out_result stable until out_ready; then out_valid=0 and return to IDLE.
  - in_ready=0 in every state except IDLE, so there is no overlap.
- Latency: out_valid rises 3 cycles after the accepting edge when no left shift is needed; 3+k cycles for k left shifts (k<=46).
- No subnormal outputs or NaN generation; flush-to-zero only.

Optional Feature:
FPU_NORM_FLAGS_EN:
- Defined: adds output out_flags[2:0] = {overflow, underflow, inexact}.
  - Registered with out_result and valid under the same handshake.
  - Reset value 0.
  - inexact = guard|sticky, or any flush/overflow.
- Undefined: port and flag logic absent; result datapath identical.

Decomposition:
- Package fpu_pkg holds:
  - Operator encodings OP_ADD=2'b00, OP_MUL=2'b10.
  - BIAS, EXP_MAX=255, FRAC_W.
  - State enum IDLE/ALIGN/SHIFT/ROUND/OUT.
- One sub-module, fpu_round_ne: combinational round-nearest-even from mant/guard/sticky/E to packed result plus flags.
- FSM and shifter stay in fpu_normalize.

Test Plan:
1. Multiply, mantissa 0x900000000000, exponent 127, sign 0 -> out_result 0x40100000 (2.25), out_valid 3 cycles after accept.
2. Add, mantissa 0x000001000000 (1.0+1.0), exponent 127 -> 0x40000000. Add, mantissa 0x000000800000 -> 0x3F800000.
3. Add cancellation, mantissa 0x000000000001, exponent 127 -> 0x34000000 after 23 shifts, out_valid 26 cycles after accept. Same with exponent 10 -> signed zero 0x00000000, underflow flag set.
4. Add, mantissa 0x000001FFFFFF, exponent 127 -> rounding carry -> 0x40800000, inexact=1.
5. Multiply, mantissa 0x800000000000, exponent 254, sign 1 -> 0xFF800000, overflow=1. Operator 2'b01 with nonzero mantissa, sign 0 -> 0x00000000.
6. Hold out_ready=0 for 5 cycles -> out_result stable, in_ready=0. Then assert rst_n low during SHIFT -> out_valid=0, in_ready=1 after release, no stale result.
